lut_sequencer: RTL and testbench

LUT_SEQUENCER -- requirements
Module: lut_sequencer

---
 rtl/lut_sequencer_if.sv | 31 +++
 rtl/lut_sequencer.sv | 140 ++++++++++++++
 tb/tb_lut_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_sequencer_if.sv
// ============================================================================
// Module   : lut_sequencer_if
// Brief    : Control, lookup and result signals of the LUT sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lut_sequencer_if;
  logic        start;
  logic        stop;
  logic        dir;
  logic [3:0]  last_idx;
  logic [3:0]  lut_addr;
  logic [3:0]  lut_data;
  logic [15:0] digits;
  logic        valid;
  logic        running;
  logic        done;

  modport master (
    output start, stop, dir, last_idx, lut_data,
    input  lut_addr, digits, valid, running, done
  );

  modport slave (
    input  start, stop, dir, last_idx, lut_data,
    output lut_addr, digits, valid, running, done
  );
endinterface

`default_nettype wire

// File: rtl/lut_sequencer.sv
// ============================================================================
// Module   : lut_sequencer
// Brief    : Steps a 4-bit table index, captures lookup results into a
//            4-digit shift register. Optional macro LUT_SEQ_ONESHOT_EN stops
//            at the first wrap and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_sequencer #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  lut_sequencer_if.slave   bus
);

  localparam logic [25:0] C_RELOAD = 26'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_addr;
  logic [3:0]  w_addr_nxt;
  logic [15:0] r_digits;
  logic [15:0] w_digits_nxt;
  logic [25:0] r_cnt;
  logic [25:0] w_cnt_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [3:0]  w_adv;

  // Next index; dir and last_idx are only meaningful at the advance edge
  always_comb begin
    w_adv = r_addr;
    if (!bus.dir) begin
      w_adv = (r_addr >= bus.last_idx) ? 4'd0 : r_addr + 4'd1;
    end else begin
      w_adv = (r_addr == 4'd0) ? bus.last_idx : r_addr - 4'd1;
    end
  end

`ifdef LUT_SEQ_ONESHOT_EN
  logic r_done;
  logic w_done_nxt;
  logic w_wrap;

  assign w_wrap = bus.dir ? (r_addr == 4'd0) : (r_addr >= bus.last_idx);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_digits_nxt = r_digits;
    w_cnt_nxt    = r_cnt;
    w_valid_nxt  = 1'b0;
`ifdef LUT_SEQ_ONESHOT_EN
    w_done_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_digits_nxt = {r_digits[11:0], bus.lut_data};
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = C_RELOAD;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 26'd0) begin
          w_addr_nxt  = w_adv;
          w_state_nxt = S_FETCH;
`ifdef LUT_SEQ_ONESHOT_EN
          if (w_wrap) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
`endif
        end else begin
          w_cnt_nxt = r_cnt - 26'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= 4'd0;
      r_digits <= 16'h0000;
      r_cnt    <= 26'd0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_digits <= w_digits_nxt;
      r_cnt    <= w_cnt_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

`ifdef LUT_SEQ_ONESHOT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
    end
  end

  assign bus.done = r_done;
`else
  assign bus.done = 1'b0;
`endif

  assign bus.lut_addr = r_addr;
  assign bus.digits   = r_digits;
  assign bus.valid    = r_valid;
  assign bus.running  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lut_sequencer.sv
// ============================================================================
// Module   : tb_lut_sequencer
// Brief    : Directed and randomized checks of lut_sequencer against an
//            event-level reference model (edges-until-capture countdown).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_sequencer;

  localparam int C_TICK = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lut_sequencer_if bus ();

  lut_sequencer #(.TICK_DIV(C_TICK)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] conv(input logic [3:0] idx);
    case (idx)
      4'd0:    conv = 4'hA;
      4'd1:    conv = 4'hA;
      4'd2:    conv = 4'hC;
      4'd3:    conv = 4'h0;
      default: conv = idx ^ 4'h5;
    endcase
  endfunction

  assign bus.lut_data = conv(bus.lut_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_left counts edges until the next capture
  logic        m_run;
  logic [3:0]  m_addr;
  logic [15:0] m_dig;
  logic        m_valid;
  logic        m_done;
  int          m_left;
  int          m_caps;

  task automatic model_edge(input bit s, input bit p, input bit r);
    bit wrap;
    if (r) begin
      m_run = 0; m_addr = 0; m_dig = 0; m_valid = 0; m_done = 0;
      m_left = 0; m_caps = 0;
    end else begin
      m_valid = 0;
      m_done  = 0;
      if (!m_run) begin
        if (s && !p) begin
          m_run  = 1;
          m_left = 1;
        end
      end else if (p) begin
        m_run = 0;
      end else if (m_left == 1) begin
        m_dig   = {m_dig[11:0], conv(m_addr)};
        m_valid = 1;
        m_caps++;
        m_left  = C_TICK + 1;
      end else if (m_left == 2) begin
        if (!bus.dir) begin
          wrap   = (m_addr >= bus.last_idx);
          m_addr = wrap ? 4'd0 : 4'(m_addr + 4'd1);
        end else begin
          wrap   = (m_addr == 4'd0);
          m_addr = wrap ? bus.last_idx : 4'(m_addr - 4'd1);
        end
        m_left = 1;
`ifdef LUT_SEQ_ONESHOT_EN
        if (wrap) begin
          m_run  = 0;
          m_done = 1;
        end
`else
        if (wrap) m_left = 1;
`endif
      end else begin
        m_left--;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("lut_addr", 32'(bus.lut_addr), 32'(m_addr));
    chk("digits",   32'(bus.digits),   32'(m_dig));
    chk("valid",    32'(bus.valid),    32'(m_valid));
    chk("running",  32'(bus.running),  32'(m_run));
    chk("done",     32'(bus.done),     32'(m_done));
  endtask

  task automatic step(input bit s, input bit p, input bit r);
    bus.start = s;
    bus.stop  = p;
    rst       = r;
    @(posedge clk);
    model_edge(s, p, r);
    #1;
    check_all();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic wait_caps(input int n);
    int guard;
    guard = 0;
    while (m_caps < n && guard < 200) begin
      step(0, 0, 0);
      guard++;
    end
    if (guard >= 200) timeout_fail("wait_caps");
  endtask

  initial begin
    int guard;
    int nvalid;
    int ndone;
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.dir   = 1'b0;
    bus.last_idx = 4'd3;
    rst       = 1'b1;
    m_run = 0; m_addr = 0; m_dig = 0; m_valid = 0; m_done = 0;
    m_left = 0; m_caps = 0;

    step(0, 0, 1);
    step(1, 0, 1);
    chk("reset_running", 32'(bus.running), 32'd0);
    chk("reset_digits",  32'(bus.digits),  32'h0000);

    // Simultaneous start and stop in IDLE
    step(1, 1, 0);
    chk("start_stop_idle", 32'(bus.running), 32'd0);
    step(0, 0, 0);

`ifdef LUT_SEQ_ONESHOT_EN
    bus.last_idx = 4'd2;
    step(1, 0, 0);
    nvalid = 0;
    ndone  = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0);
      nvalid += int'(bus.valid);
      ndone  += int'(bus.done);
    end
    chk("oneshot_valid_count", 32'(nvalid), 32'd3);
    chk("oneshot_done_count",  32'(ndone),  32'd1);
    chk("oneshot_digits",      32'(bus.digits), 32'h0AAC);
    chk("oneshot_running",     32'(bus.running), 32'd0);
    chk("oneshot_addr",        32'(bus.lut_addr), 32'd0);
    bus.last_idx = 4'd3;
`else
    // Up run
    step(1, 0, 0);
    step(0, 0, 0);
    chk("first_valid_latency", 32'(bus.valid), 32'd1);
    nvalid = 0;
    for (int i = 0; i < C_TICK; i++) begin
      step(0, 0, 0);
      nvalid += int'(bus.valid);
    end
    chk("no_valid_between", 32'(nvalid), 32'd0);
    step(0, 0, 0);
    chk("second_valid_spacing", 32'(bus.valid), 32'd1);
    wait_caps(3);
    chk("up_digits_3", 32'(bus.digits), 32'h0AAC);
    wait_caps(4);
    chk("up_digits_4", 32'(bus.digits), 32'hAAC0);
    wait_caps(5);
    chk("up_digits_5", 32'(bus.digits), 32'hAC0A);

    // Down run
    step(0, 0, 1);
    bus.dir = 1'b1;
    step(1, 0, 0);
    wait_caps(4);
    chk("down_digits_4", 32'(bus.digits), 32'hA0CA);

    // Stop and restart
    step(0, 0, 1);
    bus.dir = 1'b0;
    step(1, 0, 0);
    wait_caps(2);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("stop_running", 32'(bus.running), 32'd0);
    chk("stop_addr",    32'(bus.lut_addr), 32'd1);
    chk("stop_digits",  32'(bus.digits), 32'h00AA);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("restart_valid",  32'(bus.valid), 32'd1);
    chk("restart_digits", 32'(bus.digits), 32'h0AAA);
`endif

    // Reset while in FETCH
    step(0, 0, 1);
    step(1, 0, 0);
    wait_caps(1);
    guard = 0;
    while (!(m_run && m_left == 1) && guard < 50) begin
      step(0, 0, 0);
      guard++;
    end
    if (guard >= 50) timeout_fail("reach_fetch");
    step(0, 0, 1);
    chk("rst_fetch_valid",  32'(bus.valid), 32'd0);
    chk("rst_fetch_digits", 32'(bus.digits), 32'h0000);
    chk("rst_fetch_addr",   32'(bus.lut_addr), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.dir      = 1'($urandom_range(0, 1));
        bus.last_idx = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
